packet_tx_fifo: RTL and testbench

//  Downstream stage of the 5-pixel row encoder. Captures 16-bit encoded packets
//  (raw 0_xxx_xxx_xxx_xxx_xxx, timestamp 1_ttt..t, wrap marker 0x8000) on the encoder's
//  one-cycle data_ready strobe. Buffers them in a FIFO and streams them out as bytes

---
 rtl/packet_tx_fifo_if.sv | 21 ++
 rtl/packet_tx_fifo.sv | 138 +++++++++++++
 tb/tb_packet_tx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/packet_tx_fifo_if.sv
// rtl/packet_tx_fifo_if.sv - byte stream link from the packet FIFO to the readout sink
interface packet_tx_fifo_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_last;

    modport master (
        output tx_valid,
        output tx_byte,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_byte,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/packet_tx_fifo.sv
// rtl/packet_tx_fifo.sv - buffers 16-bit encoder packets and serializes them MSB byte first
module packet_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          encoded_data,
    input  logic                 data_ready,
    packet_tx_fifo_if.master     tx,
    output logic [ADDR_W:0]      fifo_level,
    output logic                 overflow,
    output logic [7:0]           drop_count,
    input  logic                 clr_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    state_t            state;
    logic [7:0]        hold_lo;
    logic [15:0]       head;
    logic              pop;
    logic              store;
    logic              drop;

    assign head = mem[rd_ptr];

    // Popping in SEND_LO on the final handshake keeps the link busy with no idle cycle.
    assign pop   = (fifo_level != '0) &&
                   ((state == IDLE) || ((state == SEND_LO) && tx.tx_ready));
    assign store = data_ready && ((fifo_level != FULL_LEVEL) || pop);
    assign drop  = data_ready && !store;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= encoded_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({store, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A drop on the same edge as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_lo     <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_byte  <= '0;
            tx.tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold_lo     <= head[7:0];
                        tx.tx_valid <= 1'b1;
                        tx.tx_byte  <= head[15:8];
                        tx.tx_last  <= 1'b0;
                        state       <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (tx.tx_ready) begin
                        tx.tx_byte <= hold_lo;
                        tx.tx_last <= 1'b1;
                        state      <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (tx.tx_ready) begin
                        if (pop) begin
                            hold_lo     <= head[7:0];
                            tx.tx_valid <= 1'b1;
                            tx.tx_byte  <= head[15:8];
                            tx.tx_last  <= 1'b0;
                            state       <= SEND_HI;
                        end else begin
                            tx.tx_valid <= 1'b0;
                            tx.tx_byte  <= '0;
                            tx.tx_last  <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    tx.tx_valid <= 1'b0;
                    tx.tx_byte  <= '0;
                    tx.tx_last  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx_fifo.sv
// tb/tb_packet_tx_fifo.sv - directed bench for packet_tx_fifo
module tb_packet_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] encoded_data;
    logic        data_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_overflow;

    int checks;
    int errors;

    packet_tx_fifo_if tx_if ();

    packet_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .encoded_data (encoded_data),
        .data_ready   (data_ready),
        .tx           (tx_if),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] d);
        data_ready   = 1'b1;
        encoded_data = d;
        step();
        data_ready   = 1'b0;
    endtask

    // Packs valid, last and byte so one comparison covers a whole beat.
    function automatic logic [31:0] beat(input logic v, input logic l, input logic [7:0] b);
        return {22'd0, v, l, b};
    endfunction

    logic [15:0] exp_w;

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        encoded_data   = '0;
        data_ready     = 1'b0;
        clr_overflow   = 1'b0;
        tx_if.tx_ready = 1'b0;

        step();
        step();
        chk("reset_beat", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(0, 0, 8'h00));
        chk("reset_level", fifo_level, 0);
        chk("reset_ovf", {overflow, drop_count}, 0);
        rst_n = 1'b1;
        step();

        // single packet, latency and byte order
        tx_if.tx_ready = 1'b1;
        strobe(16'h1A2B);
        chk("t1_e0_valid", tx_if.tx_valid, 0);
        chk("t1_e0_level", fifo_level, 1);
        step();
        chk("t1_hi", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 0, 8'h1A));
        chk("t1_level", fifo_level, 0);
        step();
        chk("t1_lo", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 1, 8'h2B));
        step();
        chk("t1_idle", tx_if.tx_valid, 0);

        // backpressure holds the beat stable
        tx_if.tx_ready = 1'b0;
        strobe(16'h8000);
        chk("t2_e0_valid", tx_if.tx_valid, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 0, 8'h80));
            step();
        end
        tx_if.tx_ready = 1'b1;
        step();
        chk("t2_lo", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 1, 8'h00));
        step();
        chk("t2_idle", tx_if.tx_valid, 0);
        chk("t2_level", fifo_level, 0);

        // overflow: 20 strobes, one moves to the serializer, 16 fill, 3 dropped
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_ready   = 1'b1;
            encoded_data = 16'(i);
            step();
        end
        data_ready = 1'b0;
        chk("t3_level", fifo_level, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_drops", drop_count, 3);
        chk("t3_head_hi", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 0, 8'h00));

        // full FIFO: store accepted on the same edge as a SEND_LO pop
        tx_if.tx_ready = 1'b1;
        step();
        chk("t4_w0_lo", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 1, 8'h00));
        strobe(16'hBEEF);
        chk("t4_level", fifo_level, 16);
        chk("t4_drops", drop_count, 3);
        for (int i = 1; i <= 17; i++) begin
            exp_w = (i <= 16) ? 16'(i) : 16'hBEEF;
            chk("t4_drain_hi", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 0, exp_w[15:8]));
            step();
            chk("t4_drain_lo", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 1, exp_w[7:0]));
            step();
        end
        chk("t4_idle", tx_if.tx_valid, 0);
        chk("t4_level_end", fifo_level, 0);
        chk("t4_ovf_sticky", {overflow, drop_count}, {1'b1, 8'd3});

        // async reset in SEND_LO with a word still queued
        strobe(16'h1234);
        data_ready   = 1'b1;
        encoded_data = 16'h5678;
        step();
        data_ready = 1'b0;
        step();
        chk("t5_lo", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(1, 1, 8'h34));
        chk("t5_level", fifo_level, 1);
        tx_if.tx_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_beat", beat(tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte), beat(0, 0, 8'h00));
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_ovf", {overflow, drop_count}, 0);
        step();
        rst_n          = 1'b1;
        tx_if.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_quiet", {tx_if.tx_valid, fifo_level}, 0);
        end

        // clear racing a drop, saturation, then plain clear
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            strobe(16'(16'h0100 + i));
        end
        chk("t6_full", fifo_level, 16);
        chk("t6_no_drop", overflow, 0);
        strobe(16'hDEAD);
        strobe(16'hDEAD);
        chk("t6_two_drops", drop_count, 2);
        clr_overflow = 1'b1;
        strobe(16'hDEAD);
        clr_overflow = 1'b0;
        chk("t6_race", {overflow, drop_count}, {1'b1, 8'd1});
        data_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
        end
        data_ready = 1'b0;
        chk("t6_saturate", drop_count, 255);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t6_clear", {overflow, drop_count}, 0);
        chk("t6_level_kept", fifo_level, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
